// File: rtl/aes_avalon_regs_if.sv
// Avalon-MM slave bus bundle for the AES register front-end.
// Handshake: READ/WRITE count only while CS is high; READDATA is valid the cycle after a read strobe.
interface aes_avalon_regs_if;
  logic        AVL_CS;
  logic        AVL_READ;
  logic        AVL_WRITE;
  logic [3:0]  AVL_ADDR;
  logic [3:0]  AVL_BYTE_EN;
  logic [31:0] AVL_WRITEDATA;
  logic [31:0] AVL_READDATA;

  modport master (
    output AVL_CS, AVL_READ, AVL_WRITE, AVL_ADDR, AVL_BYTE_EN, AVL_WRITEDATA,
    input  AVL_READDATA
  );

  modport slave (
    input  AVL_CS, AVL_READ, AVL_WRITE, AVL_ADDR, AVL_BYTE_EN, AVL_WRITEDATA,
    output AVL_READDATA
  );
endinterface

// File: rtl/aes_avalon_regs.sv
// Register front-end for the AES decryption core: key/ciphertext registers,
// start/done sequencing and capture of the decrypted message.
module aes_avalon_regs (
  input  logic              CLK,
  input  logic              RESET,
  aes_avalon_regs_if.slave  avl,
  output logic [31:0]       EXPORT_DATA,
  output logic              AES_START,
  input  logic              AES_DONE,
  output logic [127:0]      AES_KEY,
  output logic [127:0]      AES_MSG_ENC,
  input  logic [127:0]      AES_MSG_DEC,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, CAPT = 2'd2, FIN = 2'd3} state_t;

  state_t      state_q, state_d;
  logic [31:0] key_q [4];
  logic [31:0] key_d [4];
  logic [31:0] enc_q [4];
  logic [31:0] enc_d [4];
  logic [31:0] dec_q [4];
  logic [31:0] dec_d [4];
  logic        start_q, start_d;
  logic        done_q, done_d;
  logic [31:0] rdata_q, rdata_d;

  logic wr_en, rd_en, locked, start_wr;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] res;
    res = old;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = wd[8*b +: 8];
    end
    return res;
  endfunction

  always_comb begin
    state_d   = state_q;
    key_d     = key_q;
    enc_d     = enc_q;
    dec_d     = dec_q;
    start_d   = start_q;
    done_d    = done_q;
    AES_START = 1'b0;

    wr_en    = avl.AVL_CS & avl.AVL_WRITE;
    rd_en    = avl.AVL_CS & avl.AVL_READ & ~avl.AVL_WRITE;
    locked   = (state_q == RUN) || (state_q == CAPT);
    start_wr = wr_en && (avl.AVL_ADDR == 4'd14) && avl.AVL_BYTE_EN[0] && !locked;

    // Key and ciphertext are frozen while the core is working on them.
    if (wr_en && !locked) begin
      if (avl.AVL_ADDR[3:2] == 2'd0)
        key_d[avl.AVL_ADDR[1:0]] = merge(key_q[avl.AVL_ADDR[1:0]], avl.AVL_WRITEDATA, avl.AVL_BYTE_EN);
      if (avl.AVL_ADDR[3:2] == 2'd1)
        enc_d[avl.AVL_ADDR[1:0]] = merge(enc_q[avl.AVL_ADDR[1:0]], avl.AVL_WRITEDATA, avl.AVL_BYTE_EN);
    end

    case (state_q)
      IDLE: begin
        if (start_wr) begin
          start_d = avl.AVL_WRITEDATA[0];
          if (avl.AVL_WRITEDATA[0]) begin
            state_d = RUN;
            done_d  = 1'b0;
          end
        end
      end
      RUN: begin
        AES_START = 1'b1;
        if (AES_DONE) begin
          dec_d[0] = AES_MSG_DEC[127:96];
          dec_d[1] = AES_MSG_DEC[95:64];
          dec_d[2] = AES_MSG_DEC[63:32];
          dec_d[3] = AES_MSG_DEC[31:0];
          state_d  = CAPT;
        end
      end
      CAPT: begin
        AES_START = 1'b1;
        done_d    = 1'b1;
        state_d   = FIN;
      end
      FIN: begin
        // Restart needs START written 0 first, which drops DONE and rearms IDLE.
        if (start_wr) begin
          start_d = avl.AVL_WRITEDATA[0];
          if (!avl.AVL_WRITEDATA[0]) begin
            state_d = IDLE;
            done_d  = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    rdata_d = 32'd0;
    if (rd_en) begin
      case (avl.AVL_ADDR)
        4'd0, 4'd1, 4'd2, 4'd3:   rdata_d = key_q[avl.AVL_ADDR[1:0]];
        4'd4, 4'd5, 4'd6, 4'd7:   rdata_d = enc_q[avl.AVL_ADDR[1:0]];
        4'd8, 4'd9, 4'd10, 4'd11: rdata_d = dec_q[avl.AVL_ADDR[1:0]];
        4'd14:                    rdata_d = {31'd0, start_q};
        4'd15:                    rdata_d = {31'd0, done_q};
        default:                  rdata_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      key_q   <= '{default: '0};
      enc_q   <= '{default: '0};
      dec_q   <= '{default: '0};
      start_q <= 1'b0;
      done_q  <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      enc_q   <= enc_d;
      dec_q   <= dec_d;
      start_q <= start_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
    end
  end

  assign AES_KEY          = {key_q[0], key_q[1], key_q[2], key_q[3]};
  assign AES_MSG_ENC      = {enc_q[0], enc_q[1], enc_q[2], enc_q[3]};
  assign EXPORT_DATA      = {key_q[0][31:16], key_q[3][15:0]};
  assign avl.AVL_READDATA = rdata_q;
  assign dbg_state        = state_q;

endmodule
